// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one MIPS ALU between an execute port and a branch/address port.
module alu_arbiter #(
    parameter int          ALU_LAT   = 2,
    parameter logic [3:0]  IDLE_CODE = 4'b0101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in_1,
    input  logic [31:0] req0_in_2,
    input  logic [3:0]  req0_ctrl,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in_1,
    input  logic [31:0] req1_in_2,
    input  logic [3:0]  req1_ctrl,
    input  logic [4:0]  req1_shamt,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_out,
    output logic        resp_zero,
    output logic        resp_err,
    output logic [31:0] alu_in_1,
    output logic [31:0] alu_in_2,
    output logic [3:0]  alu_control,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      r_state;
    logic        r_ptr;
    logic        r_id;
    logic [3:0]  r_ctrl;
    logic [7:0]  r_cnt;
    logic [31:0] r_in_1;
    logic [31:0] r_in_2;
    logic [4:0]  r_shamt;
    logic [3:0]  r_alu_ctrl;
    logic [31:0] r_out;
    logic        r_zero;
    logic        r_err;
    logic        r_resp0;
    logic        r_resp1;
    logic        r_busy;

    logic        w_win0;
    logic        w_win1;
    logic        w_take;
    logic        w_sel;
    logic        w_legal;
    logic [31:0] w_in_1;
    logic [31:0] w_in_2;
    logic [3:0]  w_ctrl;
    logic [4:0]  w_shamt;

    // Arbitration: a lone requester wins; on a tie the pointer decides. Select the winner's operands.
    always_comb begin
        w_win0  = req0_valid && (!req1_valid || !r_ptr);
        w_win1  = req1_valid && (!req0_valid || r_ptr);
        w_take  = rst_n && (r_state == IDLE) && (w_win0 || w_win1);
        w_sel   = w_win1;
        w_in_1  = w_sel ? req1_in_1  : req0_in_1;
        w_in_2  = w_sel ? req1_in_2  : req0_in_2;
        w_ctrl  = w_sel ? req1_ctrl  : req0_ctrl;
        w_shamt = w_sel ? req1_shamt : req0_shamt;
        w_legal = w_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111,
                                 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1111};
    end

    assign req0_ready  = rst_n && (r_state == IDLE) && w_win0;
    assign req1_ready  = rst_n && (r_state == IDLE) && w_win1;
    assign resp0_valid = r_resp0;
    assign resp1_valid = r_resp1;
    assign resp_out    = r_out;
    assign resp_zero   = r_zero;
    assign resp_err    = r_err;
    assign alu_in_1    = r_in_1;
    assign alu_in_2    = r_in_2;
    assign alu_control = r_alu_ctrl;
    assign alu_shamt   = r_shamt;
    assign busy        = r_busy;

    // Issue/execute/respond sequencer; alu_control parks on IDLE_CODE outside EXEC so every issue is a transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_id       <= 1'b0;
            r_ctrl     <= 4'b0;
            r_cnt      <= 8'd0;
            r_in_1     <= 32'd0;
            r_in_2     <= 32'd0;
            r_shamt    <= 5'd0;
            r_alu_ctrl <= IDLE_CODE;
            r_out      <= 32'd0;
            r_zero     <= 1'b0;
            r_err      <= 1'b0;
            r_resp0    <= 1'b0;
            r_resp1    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_resp0 <= 1'b0;
            r_resp1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_id   <= w_sel;
                        r_ptr  <= !w_sel;
                        r_ctrl <= w_ctrl;
                        r_busy <= 1'b1;
                        if (w_legal) begin
                            r_state    <= EXEC;
                            r_cnt      <= 8'(ALU_LAT);
                            r_alu_ctrl <= w_ctrl;
                            r_in_1     <= w_in_1;
                            r_in_2     <= w_in_2;
                            r_shamt    <= w_shamt;
                        end else begin
                            r_state <= RESP;
                            r_out   <= 32'd0;
                            r_zero  <= 1'b0;
                            r_err   <= 1'b1;
                            r_resp0 <= !w_sel;
                            r_resp1 <= w_sel;
                        end
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state    <= RESP;
                        r_alu_ctrl <= IDLE_CODE;
                        r_out      <= alu_out;
                        r_zero     <= (r_ctrl == 4'b1010) && alu_zero;
                        r_err      <= 1'b0;
                        r_resp0    <= !r_id;
                        r_resp1    <= r_id;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed traffic on both ports, checked cycle by cycle against a transaction-level model.
module tb_alu_arbiter;
    localparam int         LAT       = 2;
    localparam logic [3:0] IDLE_CODE = 4'b0101;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  sh;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp_zero, resp_err, busy;
    logic [31:0] resp_out, alu_in_1, alu_in_2;
    logic [3:0]  alu_control;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_out = 32'd0;
    logic        alu_zero = 1'b0;
    logic        vld [2];
    op_t         cur [2];
    op_t         q0 [$];
    op_t         q1 [$];
    bit          acc [2];
    bit          rnd;
    logic [15:0] legal = 16'h9F9F;
    int          n_chk, n_err;
    int          c, free_at, ptr, resp_c, resp_p, ex_lo, ex_hi;
    op_t         mop;
    logic [31:0] e_out;
    logic        e_zero, e_err;

    alu_arbiter #(.ALU_LAT(LAT), .IDLE_CODE(IDLE_CODE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_in_1(cur[0].a), .req0_in_2(cur[0].b),
        .req0_ctrl(cur[0].ctrl), .req0_shamt(cur[0].sh),
        .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_in_1(cur[1].a), .req1_in_2(cur[1].b),
        .req1_ctrl(cur[1].ctrl), .req1_shamt(cur[1].sh),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_out(resp_out),
        .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_control(alu_control), .alu_shamt(alu_shamt),
        .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        case (ctrl)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return b << sh;
            4'b0100: return b >> sh;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return a ^ b;
            4'b1001: return a - b;
            4'b1011: return (a < b) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            4'b1111: return 32'($signed(b) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU: recomputes only when alu_control changes to a non-parking code.
    always @(alu_control) begin
        #1;
        if (alu_control != IDLE_CODE) begin
            alu_out  = alu_fn(alu_control, alu_in_1, alu_in_2, alu_shamt);
            alu_zero = (alu_control == 4'b1010) ? (alu_in_1 == alu_in_2) : (alu_out == 32'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    function automatic op_t mk(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        op_t o;
        o.ctrl = ctrl; o.a = a; o.b = b; o.sh = sh;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.ctrl = 4'($urandom_range(15));
        o.a    = $urandom;
        o.b    = ($urandom_range(3) == 0) ? o.a : $urandom;
        o.sh   = 5'($urandom_range(31));
        return o;
    endfunction

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) vld[p] = 1'b0;
            if (!vld[p]) begin
                if (p == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); vld[0] = 1'b1; end
                else if (p == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); vld[1] = 1'b1; end
                else if (rnd && $urandom_range(2) == 0) begin cur[p] = rand_op(); vld[p] = 1'b1; end
            end else if (rnd && $urandom_range(23) == 0) vld[p] = 1'b0;
        end
    endtask

    task automatic model();
        int  w;
        bit  idle;
        bit  in_ex;
        idle  = (c >= free_at);
        in_ex = (c >= ex_lo) && (c <= ex_hi);
        w = -1;
        if (vld[0] && vld[1]) w = ptr;
        else if (vld[0]) w = 0;
        else if (vld[1]) w = 1;
        check("req0_ready", 32'(req0_ready), 32'(idle && w == 0));
        check("req1_ready", 32'(req1_ready), 32'(idle && w == 1));
        check("busy", 32'(busy), 32'(!idle));
        check("alu_control", 32'(alu_control), 32'(in_ex ? mop.ctrl : IDLE_CODE));
        if (in_ex) begin
            check("alu_in_1", alu_in_1, mop.a);
            check("alu_in_2", alu_in_2, mop.b);
            check("alu_shamt", 32'(alu_shamt), 32'(mop.sh));
        end
        check("resp0_valid", 32'(resp0_valid), 32'(c == resp_c && resp_p == 0));
        check("resp1_valid", 32'(resp1_valid), 32'(c == resp_c && resp_p == 1));
        if (c == resp_c) begin
            check("resp_out", resp_out, e_out);
            check("resp_zero", 32'(resp_zero), 32'(e_zero));
            check("resp_err", 32'(resp_err), 32'(e_err));
        end
        acc[0] = vld[0] && req0_ready;
        acc[1] = vld[1] && req1_ready;
        if (idle && w >= 0) begin
            mop    = cur[w];
            ptr    = 1 - w;
            resp_p = w;
            if (legal[mop.ctrl]) begin
                ex_lo   = c + 1;
                ex_hi   = c + LAT;
                resp_c  = c + LAT + 1;
                free_at = c + LAT + 2;
                e_out   = alu_fn(mop.ctrl, mop.a, mop.b, mop.sh);
                e_zero  = (mop.ctrl == 4'b1010) && (mop.a == mop.b);
                e_err   = 1'b0;
            end else begin
                ex_lo   = 1;
                ex_hi   = 0;
                resp_c  = c + 1;
                free_at = c + 2;
                e_out   = 32'd0;
                e_zero  = 1'b0;
                e_err   = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        c++;
        #1;
        drive();
        @(negedge clk);
        model();
    endtask

    task automatic settle();
        int k;
        for (k = 0; k < 200; k++) begin
            if (q0.size() == 0 && q1.size() == 0 && !vld[0] && !vld[1] && c >= free_at) break;
            step();
        end
        if (k == 200) begin
            n_chk++;
            n_err++;
            $display("FAIL settle: traffic still pending after %0d cycles, required drained", k);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
        check({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
        check({tag, "_resp0_valid"}, 32'(resp0_valid), 32'd0);
        check({tag, "_resp1_valid"}, 32'(resp1_valid), 32'd0);
        check({tag, "_resp_out"}, resp_out, 32'd0);
        check({tag, "_resp_zero"}, 32'(resp_zero), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_alu_in_1"}, alu_in_1, 32'd0);
        check({tag, "_alu_in_2"}, alu_in_2, 32'd0);
        check({tag, "_alu_shamt"}, 32'(alu_shamt), 32'd0);
        check({tag, "_alu_control"}, 32'(alu_control), 32'(IDLE_CODE));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic model_reset();
        vld[0] = 1'b0; vld[1] = 1'b0;
        acc[0] = 1'b0; acc[1] = 1'b0;
        free_at = 0; ptr = 0; resp_c = -1; resp_p = 0; ex_lo = 1; ex_hi = 0;
    endtask

    initial begin
        int k;
        n_chk = 0; n_err = 0; c = 0; rnd = 1'b0;
        cur[0] = mk(4'b0, 32'd0, 32'd0, 5'd0);
        cur[1] = mk(4'b0, 32'd0, 32'd0, 5'd0);
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        // both valid with pointer 0: sll 1<<4 on port 0, slt 5<6 on port 1
        q0.push_back(mk(4'b0011, 32'd0, 32'd1, 5'd4));
        q1.push_back(mk(4'b0111, 32'd5, 32'd6, 5'd0));
        settle();
        q0.push_back(mk(4'b0010, 32'd3, 32'd4, 5'd0));
        settle();
        q1.push_back(mk(4'b1010, 32'h55, 32'h55, 5'd0));
        q1.push_back(mk(4'b1010, 32'h55, 32'h54, 5'd0));
        settle();
        q0.push_back(mk(4'b0110, 32'd7, 32'd1, 5'd0));
        settle();
        q1.push_back(mk(4'b0010, 32'd2, 32'd2, 5'd0));
        q1.push_back(mk(4'b0010, 32'd5, 32'd1, 5'd0));
        settle();
        // reset in the middle of an execute discards the operation
        q0.push_back(mk(4'b0010, 32'd9, 32'd9, 5'd0));
        for (k = 0; k < 20 && !acc[0]; k++) step();
        if (!acc[0]) begin
            n_chk++;
            n_err++;
            $display("FAIL issue_before_reset: no grant for port 0 in %0d cycles, required one", k);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("rst_mid");
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_checks("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        q1.push_back(mk(4'b0010, 32'd10, 32'd20, 5'd0));
        settle();
        q0.push_back(mk(4'b0001, 32'hF0, 32'h0F, 5'd0));
        q1.push_back(mk(4'b1001, 32'd50, 32'd8, 5'd0));
        settle();
        rnd = 1'b1;
        repeat (1500) step();
        rnd = 1'b0;
        settle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
